// File: rtl/dds_pkg.sv
// Shared types and width rules for the DDS waveform generator.
package dds_pkg;

    typedef enum logic [2:0] {
        WAVE_SINE   = 3'd0,
        WAVE_SQUARE = 3'd1,
        WAVE_SAW    = 3'd2,
        WAVE_TRI    = 3'd3
    } wave_mode_e;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    function automatic bit widths_legal(input int phase_w, input int addr_w, input int data_w);
        return (addr_w >= 4) && (addr_w <= phase_w) &&
               (data_w >= 4) && (data_w <= phase_w - 1);
    endfunction

endpackage

// File: rtl/dds_wavegen_quarter_sine_rom.sv
// Quarter-wave sine table, filled at elaboration from the sine formula.
module quarter_sine_rom #(
    parameter int AW     = 6,
    parameter int DATA_W = 8
) (
    input  logic [AW-1:0]     addr_a_i,
    input  logic [AW-1:0]     addr_b_i,
    output logic [DATA_W-2:0] data_a_o,
    output logic [DATA_W-2:0] data_b_o
);

    localparam int  N  = 1 << AW;
    localparam real PI = 3.14159265358979323846;

    // Sampled at bin centres so the folded quadrants join without a repeated code.
    function automatic logic [DATA_W-2:0] entry(input int k);
        real x;
        x = real'((1 << (DATA_W - 1)) - 1) * $sin(PI / 2.0 * (real'(k) + 0.5) / real'(N));
        return (DATA_W-1)'($rtoi(x + 0.5));
    endfunction

    logic [DATA_W-2:0] rom [N];

    for (genvar k = 0; k < N; k++) begin : g_rom
        localparam logic [DATA_W-2:0] V = entry(k);
        assign rom[k] = V;
    end

    assign data_a_o = rom[addr_a_i];
    assign data_b_o = rom[addr_b_i];

endmodule

// File: rtl/dds_wavegen.sv
// DDS waveform generator: phase accumulator, offset stage, and I/Q waveform shaping.
module dds_wavegen
    import dds_pkg::*;
#(
    parameter int PHASE_W = 16,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               phase_clr,
    input  logic [PHASE_W-1:0] ftw,
    input  logic [PHASE_W-1:0] phase_ofs,
    input  logic [2:0]         mode,
    output logic [DATA_W-1:0]  wave_out,
    output logic [DATA_W-1:0]  quad_out,
    output logic               out_valid,
    output logic               wrap
);

    localparam int QA_W = ADDR_W - 2;
    localparam logic [PHASE_W-1:0] QUARTER = {2'b01, {(PHASE_W-2){1'b0}}};

    if (!widths_legal(PHASE_W, ADDR_W, DATA_W)) begin : g_bad_widths
        $error("dds_wavegen: illegal PHASE_W/ADDR_W/DATA_W combination");
    end

    // Odd quadrants read the table backwards; ~i equals N-1-i.
    function automatic logic [QA_W-1:0] fold_addr(input logic [PHASE_W-1:0] ph);
        logic [1:0]      q;
        logic [QA_W-1:0] i;
        q = ph[PHASE_W-1 -: 2];
        i = ph[PHASE_W-3 -: QA_W];
        return ((q == Q1) || (q == Q3)) ? ~i : i;
    endfunction

    function automatic logic [DATA_W-1:0] shape(input logic [2:0]         md,
                                                 input logic [PHASE_W-1:0] ph,
                                                 input logic [DATA_W-2:0]  qv);
        logic [DATA_W:0] t;
        logic [1:0]      q;
        t = ph[PHASE_W-1 -: DATA_W+1];
        q = ph[PHASE_W-1 -: 2];
        case (md)
            WAVE_SINE:   shape = (q == Q2 || q == Q3) ? {1'b0, ~qv} : {1'b1, qv};
            WAVE_SQUARE: shape = ph[PHASE_W-1] ? '0 : '1;
            WAVE_SAW:    shape = ph[PHASE_W-1 -: DATA_W];
            WAVE_TRI:    shape = t[DATA_W] ? ~t[DATA_W-1:0] : t[DATA_W-1:0];
            default:     shape = {1'b1, {(DATA_W-1){1'b0}}};
        endcase
    endfunction

    logic [PHASE_W-1:0] acc_q, acc_d;
    logic               wrap_q, wrap_d;
    logic [PHASE_W-1:0] ph_p1_q, ph_p1_d;
    logic [2:0]         mode_p1_q;
    logic               vld_p1_q;
    logic [DATA_W-1:0]  wave_p2_q, wave_p2_d;
    logic [DATA_W-1:0]  quad_p2_q, quad_p2_d;
    logic               vld_p2_q;
    logic [PHASE_W-1:0] ph_quad;
    logic [DATA_W-2:0]  rom_i, rom_q;

    always_comb begin
        acc_d  = acc_q;
        wrap_d = 1'b0;
        if (phase_clr) begin
            acc_d = '0;
        end else if (en) begin
            {wrap_d, acc_d} = {1'b0, acc_q} + {1'b0, ftw};
        end
    end

    // Stage 1 sees the accumulator value from before this edge's update.
    assign ph_p1_d = acc_q + phase_ofs;
    assign ph_quad = ph_p1_q + QUARTER;

    quarter_sine_rom #(
        .AW     (QA_W),
        .DATA_W (DATA_W)
    ) u_rom (
        .addr_a_i (fold_addr(ph_p1_q)),
        .addr_b_i (fold_addr(ph_quad)),
        .data_a_o (rom_i),
        .data_b_o (rom_q)
    );

    assign wave_p2_d = shape(mode_p1_q, ph_p1_q, rom_i);
    assign quad_p2_d = shape(mode_p1_q, ph_quad, rom_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '0;
            wrap_q    <= 1'b0;
            ph_p1_q   <= '0;
            mode_p1_q <= '0;
            vld_p1_q  <= 1'b0;
            wave_p2_q <= '0;
            quad_p2_q <= '0;
            vld_p2_q  <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            wrap_q    <= wrap_d;
            ph_p1_q   <= ph_p1_d;
            mode_p1_q <= mode;
            vld_p1_q  <= en;
            wave_p2_q <= wave_p2_d;
            quad_p2_q <= quad_p2_d;
            vld_p2_q  <= vld_p1_q;
        end
    end

    assign wave_out  = wave_p2_q;
    assign quad_out  = quad_p2_q;
    assign out_valid = vld_p2_q;
    assign wrap      = wrap_q;

endmodule

// File: tb/tb_dds_wavegen.sv
// Directed bench for dds_wavegen with a per-cycle reference model and literal spot checks.
module tb_dds_wavegen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        phase_clr = 1'b0;
    logic [15:0] ftw = '0;
    logic [15:0] phase_ofs = '0;
    logic [2:0]  mode = '0;
    logic [7:0]  wave_out, quad_out;
    logic        out_valid, wrap;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dds_wavegen #(.PHASE_W(16), .ADDR_W(8), .DATA_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .phase_clr (phase_clr),
        .ftw       (ftw),
        .phase_ofs (phase_ofs),
        .mode      (mode),
        .wave_out  (wave_out),
        .quad_out  (quad_out),
        .out_valid (out_valid),
        .wrap      (wrap)
    );

    task automatic check(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== 32'(exp)) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int qrom(input int k);
        real x;
        x = 127.0 * $sin(3.14159265358979 * 0.5 * (real'(k) + 0.5) / 64.0);
        return int'($floor(x + 0.5));
    endfunction

    // Reference waveform for a 16-bit phase, 8-bit LUT index, 8-bit output.
    function automatic int wave_fn(input int md, input int ph);
        int p, q, i, t;
        p = ph / 256;
        q = p / 64;
        i = p % 64;
        t = ph / 128;
        case (md)
            0: begin
                if (q == 0)      return 128 + qrom(i);
                else if (q == 1) return 128 + qrom(63 - i);
                else if (q == 2) return 127 - qrom(i);
                else             return 127 - qrom(63 - i);
            end
            1: return (ph < 32768) ? 255 : 0;
            2: return p;
            3: return (t < 256) ? t : 511 - t;
            default: return 128;
        endcase
    endfunction

    int m_acc = 0, m_wrap = 0;
    int s_ph = 0, s_mode = 0, s_v = 0;
    int e_wave = 0, e_quad = 0, e_valid = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_acc = 0; m_wrap = 0;
            s_ph = 0; s_mode = 0; s_v = 0;
            e_wave = 0; e_quad = 0; e_valid = 0;
        end else begin
            int sum;
            e_wave  = wave_fn(s_mode, s_ph);
            e_quad  = wave_fn(s_mode, (s_ph + 16384) % 65536);
            e_valid = s_v;
            s_ph    = (m_acc + int'(phase_ofs)) % 65536;
            s_mode  = int'(mode);
            s_v     = int'(en);
            if (phase_clr) begin
                m_acc = 0; m_wrap = 0;
            end else if (en) begin
                sum    = m_acc + int'(ftw);
                m_wrap = sum / 65536;
                m_acc  = sum % 65536;
            end else begin
                m_wrap = 0;
            end
        end
    end

    always @(negedge clk) begin
        check("model_wave", {24'd0, wave_out}, e_wave);
        check("model_quad", {24'd0, quad_out}, e_quad);
        check("model_valid", {31'd0, out_valid}, e_valid);
        check("model_wrap", {31'd0, wrap}, m_wrap);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) step();
        check("reset_wave", {24'd0, wave_out}, 0);
        check("reset_quad", {24'd0, quad_out}, 0);
        check("reset_valid", {31'd0, out_valid}, 0);

        // Sine sweep
        rst_n = 1'b1; mode = 3'd0; ftw = 16'h0100; en = 1'b1;
        repeat (2) step();
        check("sine_first_wave", {24'd0, wave_out}, 130);
        check("sine_first_quad", {24'd0, quad_out}, 255);
        check("sine_first_valid", {31'd0, out_valid}, 1);
        repeat (64) step();
        check("sine_p64", {24'd0, wave_out}, 255);
        repeat (64) step();
        check("sine_p128", {24'd0, wave_out}, 125);
        repeat (64) step();
        check("sine_p192", {24'd0, wave_out}, 0);
        repeat (62) step();
        check("wrap_pulse", {31'd0, wrap}, 1);
        step();
        check("wrap_clear", {31'd0, wrap}, 0);

        // Square
        phase_clr = 1'b1; mode = 3'd1; ftw = 16'h4000;
        step();
        phase_clr = 1'b0;
        repeat (2) step();
        check("sq0_wave", {24'd0, wave_out}, 255); check("sq0_quad", {24'd0, quad_out}, 255);
        step();
        check("sq1_wave", {24'd0, wave_out}, 255); check("sq1_quad", {24'd0, quad_out}, 0);
        step();
        check("sq2_wave", {24'd0, wave_out}, 0);   check("sq2_quad", {24'd0, quad_out}, 0);
        step();
        check("sq3_wave", {24'd0, wave_out}, 0);   check("sq3_quad", {24'd0, quad_out}, 255);

        // Sawtooth
        phase_clr = 1'b1; mode = 3'd2; ftw = 16'h0100;
        step();
        phase_clr = 1'b0;
        repeat (2) step();
        check("saw_0", {24'd0, wave_out}, 0);
        repeat (100) step();
        check("saw_100", {24'd0, wave_out}, 100);
        repeat (155) step();
        check("saw_255", {24'd0, wave_out}, 255);
        step();
        check("saw_wrap", {24'd0, wave_out}, 0);

        // Triangle
        phase_clr = 1'b1; mode = 3'd3; ftw = 16'h0080;
        step();
        phase_clr = 1'b0;
        repeat (2) step();
        check("tri_0", {24'd0, wave_out}, 0);
        repeat (255) step();
        check("tri_255", {24'd0, wave_out}, 255);
        step();
        check("tri_peak", {24'd0, wave_out}, 255);
        repeat (44) step();
        check("tri_300", {24'd0, wave_out}, 211);
        repeat (212) step();
        check("tri_end", {24'd0, wave_out}, 0);

        // Clear mid-run, then offset on a held accumulator
        mode = 3'd0; ftw = 16'h0100;
        repeat (37) step();
        phase_clr = 1'b1;
        step();
        check("clr_wrap", {31'd0, wrap}, 0);
        phase_clr = 1'b0; en = 1'b0;
        repeat (2) step();
        check("clr_wave", {24'd0, wave_out}, 130);
        phase_ofs = 16'h8000;
        repeat (2) step();
        check("ofs_wave", {24'd0, wave_out}, 125);
        check("ofs_quad", {24'd0, quad_out}, 0);

        // Asynchronous reset between edges
        en = 1'b1;
        repeat (20) step();
        #2 rst_n = 1'b0;
        #1;
        check("arst_wave", {24'd0, wave_out}, 0);
        check("arst_quad", {24'd0, quad_out}, 0);
        check("arst_valid", {31'd0, out_valid}, 0);
        check("arst_wrap", {31'd0, wrap}, 0);
        step();
        rst_n = 1'b1; en = 1'b0;
        step();
        check("post_rst_valid", {31'd0, out_valid}, 0);
        step();
        check("post_rst_wave", {24'd0, wave_out}, 125);
        check("post_rst_quad", {24'd0, quad_out}, 0);
        repeat (5) step();
        check("post_rst_hold", {24'd0, wave_out}, 125);
        check("post_rst_valid2", {31'd0, out_valid}, 0);

        // Reserved mode
        phase_ofs = 16'h0000; mode = 3'd5;
        repeat (2) step();
        check("rsv_wave", {24'd0, wave_out}, 128);
        check("rsv_quad", {24'd0, quad_out}, 128);

        // Maximum tuning word
        mode = 3'd0; phase_clr = 1'b1;
        step();
        phase_clr = 1'b0; en = 1'b1; ftw = 16'hFFFF;
        step();
        check("ffff_first", {31'd0, wrap}, 0);
        step();
        check("ffff_second", {31'd0, wrap}, 1);
        step();
        check("ffff_third", {31'd0, wrap}, 1);

        // Zero tuning word
        ftw = 16'h0000; phase_clr = 1'b1;
        step();
        phase_clr = 1'b0;
        repeat (300) step();
        check("ftw0_wave", {24'd0, wave_out}, 130);
        check("ftw0_wrap", {31'd0, wrap}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dds_wavegen.md
Name: dds_wavegen

Overview:
Parametrised direct-digital-synthesis waveform generator, the next generation of the fixed 8-bit sine/cosine LUT.
- Phase accumulator of configurable width, driven by a full-width frequency tuning word, plus a phase offset.
- Quarter-wave sine ROM with symmetry folding; sine, square, sawtooth and triangle modes.
- In-phase and quadrature (+90 degree) outputs, both offset-binary, feeding the DAC/PWM stage of the function generator.

Parameters:
- PHASE_W, 16, accumulator and tuning-word width.
- ADDR_W, 8, full-period LUT index bits. Quarter ROM depth N = 2^(ADDR_W-2). Legal range 4..PHASE_W.
- DATA_W, 8, output sample width. Legal range 4..PHASE_W-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  advance the accumulator this cycle.
- phase_clr  in  1  synchronous accumulator clear.
- ftw  in  PHASE_W  frequency tuning word.
- phase_ofs  in  PHASE_W  phase offset added after the accumulator.
- mode  in  3  waveform select (see package enum).
- wave_out  out  DATA_W  in-phase sample, offset binary.
- quad_out  out  DATA_W  same waveform at phase + quarter period.
- out_valid  out  1  en delayed to match sample latency.
- wrap  out  1  one-cycle pulse on accumulator overflow.

Behaviour:
- Reset (rst_n low, asynchronous, no clock needed): acc=0, all pipeline registers=0, wave_out=0, quad_out=0, out_valid=0, wrap=0.
- Accumulator, each rising edge:
  - phase_clr=1: acc<=0, wrap<=0. phase_clr has priority over en.
  - else en=1: {carry,acc}<=acc+ftw mod 2^PHASE_W; wrap<=carry.
  - else: acc holds, wrap<=0.
- Stage 1 (registered):
  - ph1<=acc+phase_ofs mod 2^PHASE_W, using the pre-update acc value.
  - mode1<=mode; v1<=en.
- Stage 2 (registered outputs): computed from ph1 and mode1; out_valid<=v1.
  - Latency: acc value in cycle k appears at wave_out after edge k+2. mode and phase_ofs changes take effect after the same 2 edges.
  - With en=0 the pipeline keeps running on the held acc, so outputs stay constant.
- Sine (mode 0):
  - p = ph[PHASE_W-1 -: ADDR_W], q = p[ADDR_W-1:ADDR_W-2], i = p[ADDR_W-3:0], M = 2^(DATA_W-1).
  - ROM Q[k] = round((M-1)*sin(pi/2*(k+0.5)/N)), k=0..N-1.
  - q=0: M+Q[i]; q=1: M+Q[N-1-i]; q=2: M-1-Q[i]; q=3: M-1-Q[N-1-i]. Range 0..2^DATA_W-1, no overflow.
- Square (mode 1): ph MSB=0 gives 2^DATA_W-1, else 0.
- Sawtooth (mode 2): ph[PHASE_W-1 -: DATA_W].
- Triangle (mode 3):
  - t = ph[PHASE_W-1 -: DATA_W+1].
  - Output t[DATA_W-1:0] when t MSB=0, else ~t[DATA_W-1:0].
- Modes 4-7 (reserved): both outputs M.
- quad_out: the same mode evaluated at ph1 + 2^(PHASE_W-2).
- Boundary behaviour:
  - ftw=0 gives constant output and wrap never asserts.
  - Accumulator wraps modulo 2^PHASE_W silently apart from the wrap pulse.
  - Reset mid-operation discards the pipeline contents; the first valid sample after release comes 2 edges after en=1.

Decomposition:
- Package dds_pkg holds:
  - wave_mode_e enum: WAVE_SINE=0, WAVE_SQUARE=1, WAVE_SAW=2, WAVE_TRI=3.
  - Quadrant constants Q0..Q3.
  - Shared width-legality checks, applied as elaboration-time assertions.
- One sub-module, quarter_sine_rom:
  - Parameters ADDR_W-2 and DATA_W; two combinational read ports (I and Q).
  - Contents computed at elaboration from the formula; no external memory file.

Test Plan (PHASE_W=16, ADDR_W=8, DATA_W=8, N=64):
- Reset release, mode=0, ftw=0x0100, en=1 -> first out_valid sample wave_out=130, quad_out=255. wave_out reaches 255 at p=64, 125 at p=128, 0 at p=192. wrap pulses every 256 cycles.
- mode=1, ftw=0x4000 -> wave_out sequence 255,255,0,0 repeating; quad_out 255,0,0,255 repeating.
- mode=2, ftw=0x0100 -> wave_out 0,1,...,255,0. mode=3, ftw=0x0080 -> 0,1,...,255,255,254,...,0.
- phase_clr=1 together with en=1 mid-run -> acc=0, wrap=0, wave_out=130 two edges later. Then phase_ofs=0x8000 with acc held at 0 -> wave_out=125.
- rst_n asserted between clock edges mid-run -> all outputs 0 immediately. After release with en=0: out_valid stays 0 and outputs are constant.
- mode=5 -> wave_out=quad_out=128. ftw=0xFFFF from acc=0 -> wrap=1 on every update after the first.
